// File: rtl/hazard_sequencer.sv
// Hazard and stall sequencer for the 5-stage OTTER pipeline: forwarding selects,
// per-stage stall/flush controls, multi-cycle memory/multiply sequencing and perf counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemRdyM,
  input  logic             MulStartE,
  input  logic             MulDoneE,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] LP_LAST_WAIT = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LP_CNT_MAX   = '1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MUL_WAIT, ERR} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [WCNT_W-1:0] r_waitCnt;
  logic [WCNT_W-1:0] w_waitCntNext;
  logic [CNT_W-1:0]  r_stallCnt;
  logic [CNT_W-1:0]  r_flushCnt;

  logic       w_lwStall;
  logic       w_memWait;
  logic [1:0] w_fwdA;
  logic [1:0] w_fwdB;
  logic       w_stallF, w_stallD, w_stallE, w_stallM;
  logic       w_flushD, w_flushE, w_flushM, w_flushW;

  assign w_lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_memWait = MemReqM && !MemRdyM;

  // Memory-stage result wins over writeback since it is the younger producer.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      w_fwdA = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      w_fwdA = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      w_fwdB = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      w_fwdB = 2'b01;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitCntNext;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_waitCntNext = r_waitCnt;
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_stallE = 1'b0;
    w_stallM = 1'b0;
    w_flushD = 1'b0;
    w_flushE = 1'b0;
    w_flushM = 1'b0;
    w_flushW = 1'b0;
    case (r_state)
      RUN: begin
        if (w_memWait) begin
          {w_stallF, w_stallD, w_stallE, w_stallM, w_flushW} = 5'b11111;
          w_waitCntNext = '0;
          w_nextState   = MEM_WAIT;
        end else if (MulStartE && !MulDoneE) begin
          {w_stallF, w_stallD, w_stallE, w_flushM} = 4'b1111;
          w_nextState = MUL_WAIT;
        end else begin
          w_stallF = w_lwStall;
          w_stallD = w_lwStall;
          w_flushD = PCSrcE;
          w_flushE = w_lwStall | PCSrcE;
        end
      end
      MEM_WAIT: begin
        if (w_memWait) begin
          {w_stallF, w_stallD, w_stallE, w_stallM, w_flushW} = 5'b11111;
          w_waitCntNext = r_waitCnt + 1'b1;
          if (r_waitCnt == LP_LAST_WAIT)
            w_nextState = ERR;
        end else begin
          // Access completed: the pipeline moves this cycle, so ordinary hazards apply.
          w_stallF = w_lwStall;
          w_stallD = w_lwStall;
          w_flushD = PCSrcE;
          w_flushE = w_lwStall | PCSrcE;
          w_waitCntNext = '0;
          w_nextState   = RUN;
        end
      end
      MUL_WAIT: begin
        if (MulDoneE) begin
          w_nextState = RUN;
        end else begin
          {w_stallF, w_stallD, w_stallE, w_flushM} = 4'b1111;
        end
      end
      ERR: begin
        {w_stallF, w_stallD, w_stallE, w_stallM, w_flushW} = 5'b11111;
      end
      default: w_nextState = RUN;
    endcase
  end

  assign ForwardAE = RST ? 2'b00 : w_fwdA;
  assign ForwardBE = RST ? 2'b00 : w_fwdB;
  assign StallF    = w_stallF & ~RST;
  assign StallD    = w_stallD & ~RST;
  assign StallE    = w_stallE & ~RST;
  assign StallM    = w_stallM & ~RST;
  assign FlushD    = w_flushD & ~RST;
  assign FlushE    = w_flushE & ~RST;
  assign FlushM    = w_flushM & ~RST;
  assign FlushW    = w_flushW & ~RST;
  assign BusErr    = (r_state == ERR);

  // Clear beats increment; both counters stick at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else if (CntClr) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (StallF && (r_stallCnt != LP_CNT_MAX))
        r_stallCnt <= r_stallCnt + 1'b1;
      if (FlushE && (r_flushCnt != LP_CNT_MAX))
        r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign StallCnt = r_stallCnt;
  assign FlushCnt = r_flushCnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MEM_TIMEOUT=4, 4-bit counters
// so that saturation is reachable).
module tb_hazard_sequencer;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemRdyM, MulStartE, MulDoneE, CntClr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic             BusErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  logic [7:0]       ctl;

  int checks = 0;
  int errors = 0;

  hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemRdyM(MemRdyM),
    .MulStartE(MulStartE), .MulDoneE(MulDoneE), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .BusErr(BusErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  // Bit order: StallF StallD StallE StallM FlushD FlushE FlushM FlushW
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
    MemReqM = 0; MemRdyM = 0; MulStartE = 0; MulDoneE = 0; CntClr = 0;
  endtask

  task automatic clearCounters();
    CntClr = 1;
    tick();
    CntClr = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    RST = 1;
    PCSrcE = 1; Rs1E = 3; RdM = 3; RegWriteM = 1; MemReqM = 1;
    #2;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl, 8'h00); end
    checks++;
    if (ForwardAE !== 2'b00) begin errors++; $display("[TB] FAIL reset_fwdA got %b want 00", ForwardAE); end
    checks++;
    if ({BusErr, StallCnt, FlushCnt} !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_regs got busErr=%b stall=%0d flush=%0d want 0/0/0", BusErr, StallCnt, FlushCnt);
    end
    tick();
    idleInputs();
    RST = 0;
    tick();
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_ctl got %b want 00000000", ctl); end
  endtask

  task automatic test_forwarding();
    Rs1E = 5; Rs2E = 9; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin errors++; $display("[TB] FAIL fwdA_m_prio got %b want 10", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("[TB] FAIL fwdB_none got %b want 00", ForwardBE); end
    RdM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin errors++; $display("[TB] FAIL fwdA_w got %b want 01", ForwardAE); end
    RdW = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin errors++; $display("[TB] FAIL fwdA_x0 got %b want 00", ForwardAE); end
    RdM = 9; RegWriteM = 1;
    #1;
    checks++;
    if (ForwardBE !== 2'b10) begin errors++; $display("[TB] FAIL fwdB_m got %b want 10", ForwardBE); end
    RegWriteM = 0; RdW = 9; RegWriteW = 1;
    #1;
    checks++;
    if (ForwardBE !== 2'b01) begin errors++; $display("[TB] FAIL fwdB_w got %b want 01", ForwardBE); end
    RegWriteW = 0;
    #1;
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("[TB] FAIL fwdB_nowrite got %b want 00", ForwardBE); end
    idleInputs();
  endtask

  task automatic test_load_use();
    clearCounters();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    checks++;
    if (ctl !== 8'b1100_0100) begin errors++; $display("[TB] FAIL lw_stall got %b want 11000100", ctl); end
    tick();
    ResultSrcE = 2'b00; RdE = 0;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL lw_one_cycle got %b want 00000000", ctl); end
    checks++;
    if ({StallCnt, FlushCnt} !== {4'd1, 4'd1}) begin
      errors++; $display("[TB] FAIL lw_counts got stall=%0d flush=%0d want 1/1", StallCnt, FlushCnt);
    end
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL lw_x0 got %b want 00000000", ctl); end
    idleInputs();
  endtask

  task automatic test_branch();
    PCSrcE = 1;
    #1;
    checks++;
    if (ctl !== 8'b0000_1100) begin errors++; $display("[TB] FAIL branch_run got %b want 00001100", ctl); end
    MemReqM = 1; MemRdyM = 0;
    #1;
    checks++;
    if (ctl !== 8'b1111_0001) begin errors++; $display("[TB] FAIL branch_memwait got %b want 11110001", ctl); end
    tick();
    PCSrcE = 0; MemRdyM = 1;
    tick();
    idleInputs();
  endtask

  task automatic test_mem_wait();
    clearCounters();
    MemReqM = 1; MemRdyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 8'b1111_0001) begin errors++; $display("[TB] FAIL memwait_c%0d got %b want 11110001", i, ctl); end
      tick();
    end
    MemRdyM = 1;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL memwait_release got %b want 00000000", ctl); end
    tick();
    MemReqM = 0; MemRdyM = 0;
    checks++;
    if (StallCnt !== 4'd3) begin errors++; $display("[TB] FAIL memwait_cnt got %0d want 3", StallCnt); end
    MulStartE = 1;
    #1;
    checks++;
    if (ctl !== 8'b1110_0010) begin errors++; $display("[TB] FAIL memwait_back_run got %b want 11100010", ctl); end
    MulStartE = 0;
    #1;
  endtask

  task automatic test_timeout();
    MemReqM = 1; MemRdyM = 0;
    repeat (4) tick();
    checks++;
    if (BusErr !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b want 0", BusErr); end
    tick();
    checks++;
    if (BusErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got %b want 1", BusErr); end
    MemReqM = 0; MemRdyM = 1;
    repeat (3) tick();
    checks++;
    if ({BusErr, ctl} !== {1'b1, 8'b1111_0001}) begin
      errors++; $display("[TB] FAIL err_sticky got busErr=%b ctl=%b want 1/11110001", BusErr, ctl);
    end
    RST = 1;
    #1;
    checks++;
    if ({BusErr, ctl} !== 9'd0) begin errors++; $display("[TB] FAIL err_reset got busErr=%b ctl=%b want 0/0", BusErr, ctl); end
    tick();
    RST = 0;
    idleInputs();
    tick();
    checks++;
    if ({BusErr, ctl} !== 9'd0) begin errors++; $display("[TB] FAIL err_after_reset got busErr=%b ctl=%b want 0/0", BusErr, ctl); end
  endtask

  task automatic test_multiply();
    clearCounters();
    MulStartE = 1; MulDoneE = 0; MemReqM = 1; MemRdyM = 0;
    #1;
    checks++;
    if (ctl !== 8'b1111_0001) begin errors++; $display("[TB] FAIL mul_mem_first got %b want 11110001", ctl); end
    tick();
    MemRdyM = 1;
    #1;
    checks++;
    if (StallF !== 1'b0) begin errors++; $display("[TB] FAIL mul_mem_release got %b want 0", StallF); end
    tick();
    MemReqM = 0; MemRdyM = 0;
    #1;
    checks++;
    if (ctl !== 8'b1110_0010) begin errors++; $display("[TB] FAIL mul_detect got %b want 11100010", ctl); end
    tick();
    PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 8'b1110_0010) begin errors++; $display("[TB] FAIL mul_wait_c%0d got %b want 11100010", i, ctl); end
      tick();
      PCSrcE = 0;
    end
    MulDoneE = 1;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL mul_done got %b want 00000000", ctl); end
    tick();
    MulStartE = 0; MulDoneE = 0;
    checks++;
    if ({StallCnt, FlushCnt} !== {4'd5, 4'd0}) begin
      errors++; $display("[TB] FAIL mul_counts got stall=%0d flush=%0d want 5/0", StallCnt, FlushCnt);
    end
    clearCounters();
    checks++;
    if ({StallCnt, FlushCnt} !== 8'd0) begin
      errors++; $display("[TB] FAIL cntclr got stall=%0d flush=%0d want 0/0", StallCnt, FlushCnt);
    end
  endtask

  task automatic test_saturation();
    clearCounters();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    repeat (14) tick();
    checks++;
    if ({StallCnt, FlushCnt} !== {4'd14, 4'd14}) begin
      errors++; $display("[TB] FAIL sat_pre got stall=%0d flush=%0d want 14/14", StallCnt, FlushCnt);
    end
    repeat (6) tick();
    checks++;
    if ({StallCnt, FlushCnt} !== {4'd15, 4'd15}) begin
      errors++; $display("[TB] FAIL sat_hold got stall=%0d flush=%0d want 15/15", StallCnt, FlushCnt);
    end
    CntClr = 1;
    tick();
    checks++;
    if ({StallCnt, FlushCnt} !== 8'd0) begin
      errors++; $display("[TB] FAIL clr_prio got stall=%0d flush=%0d want 0/0", StallCnt, FlushCnt);
    end
    CntClr = 0;
    tick();
    checks++;
    if ({StallCnt, FlushCnt} !== {4'd1, 4'd1}) begin
      errors++; $display("[TB] FAIL clr_resume got stall=%0d flush=%0d want 1/1", StallCnt, FlushCnt);
    end
    idleInputs();
  endtask

  task automatic test_reset_midwait();
    MemReqM = 1; MemRdyM = 0;
    repeat (2) tick();
    #2;
    RST = 1;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("[TB] FAIL midwait_reset got %b want 00000000", ctl); end
    tick();
    MemReqM = 0; MulStartE = 1;
    RST = 0;
    #1;
    checks++;
    if (ctl !== 8'b1110_0010) begin errors++; $display("[TB] FAIL midwait_run got %b want 11100010", ctl); end
    idleInputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_multiply();
    test_saturation();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
